chunked_addsub_ctrl: RTL and testbench
======================================

Name: chunked_addsub_ctrl

Overview:
- Multi-cycle controller that time-shares one W-bit ripple-carry chunk adder across an N-bit add or subtract.
- Processes one W-bit chunk per cycle, LSB first, with a registered carry between chunks.
- Trades latency for area wherever a full N-bit adder is too large.
- Sits between a requester (valid/ready command port) and a consumer (valid/ready result port).

Parameters:
- N, 32, operand/result width; must be a multiple of W.
- W, 8, chunk (datapath adder) width; K = N/W cycles per operation; K=1 is legal.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  command valid.
- start_ready  output  1  controller can accept a command.
- op  input  1  0: result = b + a; 1: result = b - a.
- a  input  N  operand A.
- b  input  N  operand B.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- result  output  N  sum/difference, modulo 2^N.
- cout  output  1  final carry out of MSB chunk. For sub: 1 = no borrow (b >= a unsigned).
- busy  output  1  high in RUN and DONE.

Behaviour:
- Reset values: state=IDLE, start_ready=1, res_valid=0, result=0, cout=0, busy=0; chunk index=0, carry reg=0.
- States:
  - IDLE: start_ready=1.
  - RUN: computes chunks.
  - DONE: res_valid=1.
- IDLE -> RUN on start_valid && start_ready.
  - Capture a, b, op into registers; carry reg <= op; idx <= 0.
  - Port inputs are ignored after capture.
- Operand mapping (subtract is two's complement):
  - x = b chunk.
  - y = op ? ~a chunk : a chunk.
  - Initial carry-in = op, so b + ~a + 1.
- RUN: each cycle, chunk idx of result <= (x + y + carry) low W bits; carry reg <= chunk carry out; idx <= idx+1.
- RUN -> DONE on the edge processing idx == K-1; cout <= that chunk's carry out.
- Latency:
  - Accept edge at cycle 0; K RUN cycles; res_valid first high in cycle K+1.
  - K=1: one RUN cycle.
- DONE:
  - res_valid=1; result and cout held stable while res_ready=0 (arbitrary stall length).
  - start_ready=0; start_valid ignored.
- DONE -> IDLE on res_valid && res_ready; result/cout retain their values after handoff.
- Throughput: one command per K+2 cycles max (accept, K RUN, DONE), since start_ready is only high in IDLE.
- Handshake rules:
  - start_ready is not a function of start_valid.
  - res_valid, once high, stays high until the handshake.
- result contents during RUN are undefined to consumers; only valid with res_valid.
- Reset mid-operation (RUN or DONE): next cycle is IDLE with all reset values. Partial result is discarded; no res_valid is produced for the aborted command.
- Arithmetic: unsigned modulo 2^N. No saturation; cout is the sole overflow/borrow indicator unless the optional feature is enabled.

Optional Feature:
- Macro: ADDSUB_OVF_FLAG_EN.
- Defined:
  - Adds output ovf (1 bit), reset 0.
  - Set with cout at RUN -> DONE: ovf = signed two's-complement overflow of the N-bit operation (carry into MSB xor carry out of MSB, using the effective operand y).
  - Held with result.
- Undefined: port ovf and its logic absent; all other behaviour identical.

Test Plan (N=32, W=8):
- Add: a=0x00000001, b=0xFFFFFFFF, op=0 -> result=0x00000000, cout=1; res_valid first high exactly 5 cycles after accept edge.
- Sub with borrow: a=5, b=3, op=1 -> result=0xFFFFFFFE, cout=0. Equal sub: a=b=0x12345678, op=1 -> result=0, cout=1.
- Backpressure: complete add 0x0000FFFF+0x00000001, hold res_ready=0 for 10 cycles while start_valid=1 with new operands -> result=0x00010000 stable, start_ready=0, no second accept. Then res_ready=1 -> IDLE next cycle, new command accepted.
- Operand isolation: change a/b on the ports every cycle during RUN -> result matches captured operands only.
- Reset mid-RUN: assert rst on 2nd RUN cycle -> next cycle start_ready=1, res_valid=0, busy=0, result=0. Subsequent command computes correctly.
- With ADDSUB_OVF_FLAG_EN:
  - 0x7FFFFFFF + 0x00000001 add -> ovf=1, cout=0.
  - b=0x80000000 minus a=1 -> result=0x7FFFFFFF, ovf=1.
  - Also run with W=32 (K=1) -> res_valid 2 cycles after accept.

Source files
------------

// File: rtl/chunked_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// chunked_addsub_ctrl
//
// Multi-cycle N-bit add/subtract built around a single W-bit ripple-carry chunk
// adder. One chunk is processed per cycle, LSB first, and the carry is kept in
// a register between chunks. An operation takes K = N/W RUN cycles.
// Subtraction is b + ~a + 1: the effective operand y is ~a and the initial
// carry-in is 1.
//
// Parameters:
//   N  operand/result width (must be a multiple of W)
//   W  chunk adder width; K = N/W cycles per operation (K = 1 is legal)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   start_valid  command valid
//   start_ready  controller can accept a command (high only in IDLE)
//   op           0: result = b + a, 1: result = b - a
//   a, b         operands, captured on the accept edge
//   res_valid    result valid (DONE state)
//   res_ready    consumer accepts result
//   result       sum/difference modulo 2^N, held until the next operation
//   cout         carry out of the MSB chunk (for subtract: 1 = no borrow)
//   ovf          signed overflow flag (only with ADDSUB_OVF_FLAG_EN defined)
//   busy         high in RUN and DONE
//
// Optional feature macro: ADDSUB_OVF_FLAG_EN adds the ovf output.
// -----------------------------------------------------------------------------
module chunked_addsub_ctrl #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] result,
    output logic         cout,
`ifdef ADDSUB_OVF_FLAG_EN
    output logic         ovf,
`endif
    output logic         busy
);

    localparam int K     = N / W;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [N-1:0]       a_reg;
    logic [N-1:0]       b_reg;
    logic               op_reg;
    logic               carry;
    logic [IDX_W-1:0]   idx;

    logic [W-1:0]       x_chunk;
    logic [W-1:0]       y_chunk;
    logic [W:0]         chunk_sum;
    logic               last_chunk;
    logic               accept;

    // ---------------------------------------------------------------------
    // Chunk datapath: one W-bit slice of b plus the effective slice of a.
    // ---------------------------------------------------------------------
    always_comb begin
        x_chunk    = b_reg[int'(idx)*W +: W];
        y_chunk    = op_reg ? ~a_reg[int'(idx)*W +: W] : a_reg[int'(idx)*W +: W];
        chunk_sum  = {1'b0, x_chunk} + {1'b0, y_chunk} + {{W{1'b0}}, carry};
        last_chunk = (idx == IDX_W'(K - 1));
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ---------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = start_valid && start_ready;

    // ---------------------------------------------------------------------
    // Operand capture
    // ---------------------------------------------------------------------
    // NOTE: the operand registers have no reset; they are always loaded on the
    // accept edge before RUN reads them, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= a;
            b_reg <= b;
        end
    end

    // ---------------------------------------------------------------------
    // Control and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
`ifdef ADDSUB_OVF_FLAG_EN
            ovf    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_reg <= op;
                carry  <= op;   // +1 of the two's-complement negation of a
                idx    <= '0;
            end
            if (state == RUN) begin
                result[int'(idx)*W +: W] <= chunk_sum[W-1:0];
                carry                    <= chunk_sum[W];
                idx                      <= idx + IDX_W'(1);
                if (last_chunk) begin
                    cout <= chunk_sum[W];
`ifdef ADDSUB_OVF_FLAG_EN
                    // Carry into MSB xor carry out of MSB, expressed as: both
                    // operand signs equal and the sum sign differs.
                    ovf  <= (x_chunk[W-1] == y_chunk[W-1]) &&
                            (chunk_sum[W-1] != x_chunk[W-1]);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for chunked_addsub_ctrl (N = 32). Expected values are
// hand-computed constants. Define ADDSUB_OVF_FLAG_EN to cover the ovf output;
// override W (e.g. 32) to exercise other chunk counts.
// -----------------------------------------------------------------------------
module tb_chunked_addsub_ctrl;

    localparam int N = 32;
    parameter  int W = 8;
    localparam int K = N / W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] result;
    logic         cout;
    logic         busy;
`ifdef ADDSUB_OVF_FLAG_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    chunked_addsub_ctrl #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
`ifdef ADDSUB_OVF_FLAG_EN
        .ovf         (ovf),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE and wait (bounded) for res_valid. lat is the
    // number of edges after the accept edge until res_valid is seen, or -1.
    // With scramble set, the operand ports change every RUN cycle.
    task automatic issue(input logic op_i, input logic [N-1:0] a_i,
                         input logic [N-1:0] b_i, input bit scramble,
                         output int lat);
        start_valid = 1'b1;
        op          = op_i;
        a           = a_i;
        b           = b_i;
        tick();
        start_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 100) begin
            if (scramble) begin
                a  = $urandom;
                b  = $urandom;
                op = ~op;
            end
            tick();
            lat++;
        end
        if (!res_valid) lat = -1;
    endtask

    task automatic handoff();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
        op = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (start_ready !== 1'b1) begin n_bad++; $display("FAIL reset_start_ready: got %b, required 1", start_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b, required 0", res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h, required 00000000", result); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b, required 0", cout); end
`ifdef ADDSUB_OVF_FLAG_EN
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
`endif
    endtask

    task automatic test_add();
        int lat;
        issue(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, lat);
        n_cmp++; if (lat !== K) begin n_bad++; $display("FAIL add_latency: got %0d edges, required %0d", lat, K); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL add_result: got %h, required 00000000", result); end
        n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL add_cout: got %b, required 1", cout); end
        n_cmp++; if (busy !== 1'b1 || start_ready !== 1'b0) begin n_bad++; $display("FAIL add_done_flags: got busy=%b start_ready=%b, required 1/0", busy, start_ready); end
`ifdef ADDSUB_OVF_FLAG_EN
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL add_ovf: got %b, required 0", ovf); end
`endif
        handoff();
        n_cmp++; if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL add_handoff: got res_valid=%b start_ready=%b busy=%b, required 0/1/0", res_valid, start_ready, busy); end
        n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL add_cout_retained: got %b, required 1", cout); end
    endtask

    task automatic test_sub();
        int lat;
        issue(1'b1, 32'd5, 32'd3, 1'b0, lat);
        n_cmp++; if (lat !== K) begin n_bad++; $display("FAIL sub_borrow_latency: got %0d, required %0d", lat, K); end
        n_cmp++; if (result !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL sub_borrow_result: got %h, required fffffffe", result); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL sub_borrow_cout: got %b, required 0", cout); end
`ifdef ADDSUB_OVF_FLAG_EN
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL sub_borrow_ovf: got %b, required 0", ovf); end
`endif
        handoff();
        n_cmp++; if (result !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL sub_result_retained: got %h, required fffffffe", result); end
        issue(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, lat);
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL sub_equal_result: got %h, required 00000000", result); end
        n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL sub_equal_cout: got %b, required 1", cout); end
        handoff();
    endtask

    task automatic test_backpressure();
        int lat;
        issue(1'b0, 32'h0000_0001, 32'h0000_FFFF, 1'b0, lat);
        n_cmp++; if (result !== 32'h0001_0000) begin n_bad++; $display("FAIL bp_result: got %h, required 00010000", result); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL bp_cout: got %b, required 0", cout); end
        // New command offered while the result is stalled.
        start_valid = 1'b1; op = 1'b0; a = 32'h0000_0010; b = 32'h0000_0020;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (res_valid !== 1'b1 || result !== 32'h0001_0000 || start_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_stall_%0d: got res_valid=%b result=%h start_ready=%b, required 1/00010000/0", i, res_valid, result, start_ready);
            end
        end
        handoff();
        n_cmp++; if (start_ready !== 1'b1 || res_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_idle: got start_ready=%b res_valid=%b, required 1/0", start_ready, res_valid); end
        issue(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0, lat);
        n_cmp++; if (lat !== K || result !== 32'h0000_0030) begin n_bad++; $display("FAIL bp_next_cmd: got lat=%0d result=%h, required %0d/00000030", lat, result, K); end
        handoff();
    endtask

    task automatic test_operand_isolation();
        int lat;
        issue(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b1, lat);
        n_cmp++; if (result !== 32'h1111_1111) begin n_bad++; $display("FAIL iso_result: got %h, required 11111111", result); end
        n_cmp++; if (cout !== 1'b1) begin n_bad++; $display("FAIL iso_cout: got %b, required 1", cout); end
        handoff();
        issue(1'b0, 32'h89AB_CDEF, 32'h0123_4567, 1'b1, lat);
        n_cmp++; if (result !== 32'h8ACF_1356 || cout !== 1'b0) begin n_bad++; $display("FAIL iso_add: got %h/%b, required 8acf1356/0", result, cout); end
        handoff();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_valid = 1'b1; op = 1'b0; a = 32'hAAAA_AAAA; b = 32'h5555_5555;
        tick();                 // accept edge
        start_valid = 1'b0;
        tick();                 // now in 2nd RUN cycle (K > 1)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_run_flags: got start_ready=%b res_valid=%b busy=%b, required 1/0/0", start_ready, res_valid, busy); end
        n_cmp++; if (result !== 32'h0 || cout !== 1'b0) begin n_bad++; $display("FAIL rst_run_result: got %h/%b, required 00000000/0", result, cout); end
        for (int i = 0; i < K + 2; i++) begin
            tick();
            n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_run_no_result_%0d: got res_valid=%b, required 0", i, res_valid); end
        end
        issue(1'b0, 32'h0101_0101, 32'h0F0F_0F0F, 1'b0, lat);
        n_cmp++; if (lat !== K || result !== 32'h1010_1010 || cout !== 1'b0) begin n_bad++; $display("FAIL rst_run_after: got lat=%0d result=%h cout=%b, required %0d/10101010/0", lat, result, cout, K); end
        handoff();
    endtask

`ifdef ADDSUB_OVF_FLAG_EN
    task automatic test_ovf();
        int lat;
        issue(1'b0, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, lat);
        n_cmp++; if (result !== 32'h8000_0000 || ovf !== 1'b1 || cout !== 1'b0) begin n_bad++; $display("FAIL ovf_add: got %h ovf=%b cout=%b, required 80000000/1/0", result, ovf, cout); end
        handoff();
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_retained: got %b, required 1", ovf); end
        issue(1'b1, 32'h0000_0001, 32'h8000_0000, 1'b0, lat);
        n_cmp++; if (result !== 32'h7FFF_FFFF || ovf !== 1'b1 || cout !== 1'b1) begin n_bad++; $display("FAIL ovf_sub: got %h ovf=%b cout=%b, required 7fffffff/1/1", result, ovf, cout); end
        handoff();
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_operand_isolation();
        if (K > 1) test_reset_mid_run();
`ifdef ADDSUB_OVF_FLAG_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
